// File: rtl/pulse_mon_pkg.sv
// Shared definitions for the pulse-rate monitor: default widths and FSM state encoding.
package pulse_mon_pkg;

    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_WIN_W = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCount   = 2'b01,
        StReport  = 2'b10,
        StInvalid = 2'b11
    } mon_state_e;

endpackage

// File: rtl/pulse_rate_monitor_if.sv
// Control, pulse input and result-handshake signals of the pulse-rate monitor.
interface pulse_rate_monitor_if
    import pulse_mon_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned WIN_W = DEF_WIN_W
);

    logic             enable;
    logic             pulse_in;
    logic [WIN_W-1:0] window_len;
    logic [CNT_W-1:0] threshold;
    logic             rdy;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             alarm;
    logic             overflow;
    logic [1:0]       state;

    modport master (
        output enable, pulse_in, window_len, threshold, rdy,
        input  count_out, count_valid, alarm, overflow, state
    );

    modport slave (
        input  enable, pulse_in, window_len, threshold, rdy,
        output count_out, count_valid, alarm, overflow, state
    );

endinterface

// File: rtl/pulse_rate_monitor_window_timer.sv
// Window timer: captures the window length on load, counts cycles, flags the last window cycle.
module window_timer
    import pulse_mon_pkg::*;
#(
    parameter int unsigned WIN_W = DEF_WIN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [WIN_W-1:0] load_len,
    output logic             last
);

    logic [WIN_W-1:0] timer_q;
    logic [WIN_W-1:0] len_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            len_q   <= '0;
        end else if (load) begin
            timer_q <= '0;
            // A zero length would never terminate; run it as a single-cycle window.
            len_q   <= (load_len == '0) ? WIN_W'(1) : load_len;
        end else if (inc) begin
            timer_q <= timer_q + WIN_W'(1);
        end
    end

    assign last = (timer_q == (len_q - WIN_W'(1)));

endmodule

// File: rtl/pulse_rate_monitor.sv
// Counts pulses over back-to-back windows and reports each count through a valid/rdy handshake.
module pulse_rate_monitor
    import pulse_mon_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned WIN_W = DEF_WIN_W
) (
    input logic                 clock,
    input logic                 reset,
    pulse_rate_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             alarm_q, alarm_d;
    logic             overflow_q, overflow_d;
    logic             start;
    logic             inc;
    logic             last;

    window_timer #(
        .WIN_W (WIN_W)
    ) u_window_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (start),
        .inc      (inc),
        .load_len (bus.window_len),
        .last     (last)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        thr_d      = thr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;
        alarm_d    = alarm_q;
        overflow_d = overflow_q;
        start      = 1'b0;
        inc        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StCount;
                    start   = 1'b1;
                end
            end
            StCount: begin
                // Abort wins over window end; the partial count is simply dropped.
                if (!bus.enable) begin
                    state_d = StIdle;
                end else begin
                    inc = !last;
                    if (bus.pulse_in) begin
                        if (cnt_q == CntMax) ovf_d = 1'b1;
                        else                 cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (last) begin
                        count_d    = cnt_d;
                        valid_d    = 1'b1;
                        alarm_d    = (cnt_d >= thr_q);
                        overflow_d = ovf_d;
                        state_d    = StReport;
                    end
                end
            end
            StReport: begin
                if (valid_q && bus.rdy) begin
                    valid_d = 1'b0;
                    if (bus.enable) begin
                        state_d = StCount;
                        start   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            cnt_d = '0;
            ovf_d = 1'b0;
            thr_d = bus.threshold;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            thr_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            alarm_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            thr_q      <= thr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            alarm_q    <= alarm_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.count_out   = count_q;
    assign bus.count_valid = valid_q;
    assign bus.alarm       = alarm_q;
    assign bus.overflow    = overflow_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_pulse_rate_monitor.sv
// Self-checking bench for pulse_rate_monitor: vector table, directed corner cases, random windows.
module tb_pulse_rate_monitor;
    import pulse_mon_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    pulse_rate_monitor_if #(.CNT_W(8), .WIN_W(8)) bus8 ();
    pulse_rate_monitor_if #(.CNT_W(4), .WIN_W(8)) bus4 ();

    pulse_rate_monitor #(.CNT_W(8), .WIN_W(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8)
    );

    pulse_rate_monitor #(.CNT_W(4), .WIN_W(8)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    typedef struct {
        int          len;
        int          thr;
        logic [31:0] mask;
        int          delay;
        int          exp_cnt;
        int          exp_alarm;
        int          exp_ovf;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   pat [0:299];
    vec_t tbl [9];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One window on the 8-bit instance starting from IDLE, pulses taken from pat[].
    task automatic run_window(input string name, input int len, input int thr, input int delay,
                              input int exp_cnt, input int exp_alarm, input int exp_ovf);
        int eff;
        eff = (len == 0) ? 1 : len;
        bus8.enable     = 1'b1;
        bus8.window_len = len[7:0];
        bus8.threshold  = thr[7:0];
        bus8.rdy        = 1'b0;
        bus8.pulse_in   = 1'b0;
        step();
        check({name, " enter state"}, int'(bus8.state), 1);
        for (int i = 0; i < eff; i++) begin
            bus8.pulse_in = pat[i];
            if (i == eff - 1) check({name, " valid before end"}, int'(bus8.count_valid), 0);
            step();
        end
        bus8.pulse_in = 1'b0;
        check({name, " state"}, int'(bus8.state), 2);
        check({name, " valid"}, int'(bus8.count_valid), 1);
        check({name, " count"}, int'(bus8.count_out), exp_cnt);
        check({name, " alarm"}, int'(bus8.alarm), exp_alarm);
        check({name, " overflow"}, int'(bus8.overflow), exp_ovf);
        for (int d = 0; d < delay; d++) begin
            bus8.pulse_in = 1'($urandom);
            bus8.enable   = 1'($urandom);
            step();
            check({name, " valid held"}, int'(bus8.count_valid), 1);
            check({name, " count held"}, int'(bus8.count_out), exp_cnt);
        end
        bus8.rdy      = 1'b1;
        bus8.enable   = 1'b0;
        bus8.pulse_in = 1'b0;
        step();
        check({name, " valid cleared"}, int'(bus8.count_valid), 0);
        check({name, " back to idle"}, int'(bus8.state), 0);
        bus8.rdy = 1'b0;
    endtask

    initial begin
        int len, thr, dens, sum, eff, exp_cnt;
        logic [3:0] bp_pat;

        reset           = 1'b1;
        bus8.enable     = 1'b0;
        bus8.pulse_in   = 1'b0;
        bus8.window_len = '0;
        bus8.threshold  = '0;
        bus8.rdy        = 1'b0;
        bus4.enable     = 1'b0;
        bus4.pulse_in   = 1'b0;
        bus4.window_len = '0;
        bus4.threshold  = '0;
        bus4.rdy        = 1'b0;

        tbl[0] = '{8,  3,  32'h0000_0092, 0, 3,  1, 0};
        tbl[1] = '{0,  1,  32'h0000_0001, 0, 1,  1, 0};
        tbl[2] = '{5,  0,  32'h0000_0000, 0, 0,  1, 0};
        tbl[3] = '{1,  2,  32'h0000_0001, 0, 1,  0, 0};
        tbl[4] = '{16, 9,  32'h0000_FFFF, 2, 16, 1, 0};
        tbl[5] = '{10, 6,  32'h0000_02AA, 0, 5,  0, 0};
        tbl[6] = '{3,  4,  32'h0000_0005, 3, 2,  0, 0};
        tbl[7] = '{32, 32, 32'hFFFF_FFFF, 1, 32, 1, 0};
        tbl[8] = '{6,  2,  32'h0000_0FC0, 0, 0,  0, 0};

        step();
        step();
        check("reset state", int'(bus8.state), 0);
        check("reset valid", int'(bus8.count_valid), 0);
        check("reset count", int'(bus8.count_out), 0);
        check("reset alarm", int'(bus8.alarm), 0);
        check("reset overflow", int'(bus8.overflow), 0);
        check("reset valid w4", int'(bus4.count_valid), 0);
        reset = 1'b0;
        step();
        check("idle after reset", int'(bus8.state), 0);

        // Basic window, rdy held high: count_valid for exactly one cycle.
        bus8.enable = 1'b1; bus8.window_len = 8'd8; bus8.threshold = 8'd3; bus8.rdy = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            bus8.pulse_in = (i == 1 || i == 4 || i == 7);
            check("basic valid low in window", int'(bus8.count_valid), 0);
            step();
        end
        bus8.pulse_in = 1'b0;
        check("basic valid", int'(bus8.count_valid), 1);
        check("basic count", int'(bus8.count_out), 3);
        check("basic alarm", int'(bus8.alarm), 1);
        check("basic overflow", int'(bus8.overflow), 0);
        check("basic state", int'(bus8.state), 2);
        step();
        check("basic valid one cycle", int'(bus8.count_valid), 0);
        check("basic restart", int'(bus8.state), 1);
        bus8.enable = 1'b0; bus8.rdy = 1'b0;
        step();
        check("basic stop", int'(bus8.state), 0);

        // Abort at cycle 3 of an 8-cycle window.
        bus8.enable = 1'b1; bus8.window_len = 8'd8; bus8.threshold = 8'd1; bus8.pulse_in = 1'b1;
        step();
        step(); step(); step();
        bus8.enable = 1'b0;
        step();
        bus8.pulse_in = 1'b0;
        check("abort state", int'(bus8.state), 0);
        check("abort valid", int'(bus8.count_valid), 0);
        check("abort count kept", int'(bus8.count_out), 3);
        check("abort alarm kept", int'(bus8.alarm), 1);
        step(); step();
        check("abort valid stays low", int'(bus8.count_valid), 0);

        // Backpressure with pulses and enable toggling during REPORT.
        bp_pat = 4'b0110;
        bus8.enable = 1'b1; bus8.window_len = 8'd4; bus8.threshold = 8'd5; bus8.rdy = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            bus8.pulse_in = bp_pat[i];
            step();
        end
        check("bp valid", int'(bus8.count_valid), 1);
        check("bp count", int'(bus8.count_out), 2);
        check("bp alarm", int'(bus8.alarm), 0);
        for (int d = 0; d < 5; d++) begin
            bus8.pulse_in = 1'b1;
            bus8.enable   = !(d == 1 || d == 2);
            step();
            check("bp valid held", int'(bus8.count_valid), 1);
            check("bp count stable", int'(bus8.count_out), 2);
        end
        bus8.rdy = 1'b1; bus8.enable = 1'b1; bus8.threshold = 8'd0; bus8.pulse_in = 1'b1;
        step();
        check("bp handshake valid", int'(bus8.count_valid), 0);
        check("bp handshake state", int'(bus8.state), 1);
        bus8.rdy = 1'b0; bus8.pulse_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("bp next valid", int'(bus8.count_valid), 1);
        check("bp next count", int'(bus8.count_out), 0);
        check("bp next alarm thr0", int'(bus8.alarm), 1);
        bus8.rdy = 1'b1; bus8.enable = 1'b0;
        step();
        check("bp idle", int'(bus8.state), 0);
        bus8.rdy = 1'b0;

        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 32; i++) pat[i] = tbl[k].mask[i];
            run_window($sformatf("vec%0d", k), tbl[k].len, tbl[k].thr, tbl[k].delay,
                       tbl[k].exp_cnt, tbl[k].exp_alarm, tbl[k].exp_ovf);
        end

        // Longest window on the 8-bit instance reaches full scale without overflow.
        for (int i = 0; i < 255; i++) pat[i] = 1'b1;
        run_window("sat255", 255, 255, 0, 255, 1, 0);

        // 4-bit counter saturates and flags overflow.
        bus4.enable = 1'b1; bus4.window_len = 8'd20; bus4.threshold = 4'd15; bus4.rdy = 1'b0;
        bus4.pulse_in = 1'b1;
        step();
        for (int i = 0; i < 20; i++) step();
        bus4.pulse_in = 1'b0;
        check("w4 valid", int'(bus4.count_valid), 1);
        check("w4 count", int'(bus4.count_out), 15);
        check("w4 overflow", int'(bus4.overflow), 1);
        check("w4 alarm", int'(bus4.alarm), 1);
        bus4.rdy = 1'b1; bus4.enable = 1'b0;
        step();
        check("w4 handshake", int'(bus4.count_valid), 0);
        bus4.rdy = 1'b0;

        for (int r = 0; r < 30; r++) begin
            len  = $urandom_range(0, 40);
            thr  = $urandom_range(0, 25);
            dens = $urandom_range(0, 100);
            eff  = (len == 0) ? 1 : len;
            sum  = 0;
            for (int i = 0; i < eff; i++) begin
                pat[i] = ($urandom_range(0, 99) < dens);
                sum   += int'(pat[i]);
            end
            exp_cnt = (sum > 255) ? 255 : sum;
            run_window($sformatf("rand%0d", r), len, thr, $urandom_range(0, 3),
                       exp_cnt, int'(exp_cnt >= thr), int'(sum > 255));
        end

        // Asynchronous reset while a result is pending.
        bus8.enable = 1'b1; bus8.window_len = 8'd2; bus8.threshold = 8'd0; bus8.rdy = 1'b0;
        bus8.pulse_in = 1'b1;
        step();
        step(); step();
        bus8.pulse_in = 1'b0; bus8.enable = 1'b0;
        check("areset pre valid", int'(bus8.count_valid), 1);
        check("areset pre count", int'(bus8.count_out), 2);
        #2 reset = 1'b1;
        #1;
        check("areset valid", int'(bus8.count_valid), 0);
        check("areset state", int'(bus8.state), 0);
        check("areset count", int'(bus8.count_out), 0);
        check("areset alarm", int'(bus8.alarm), 0);
        #2 reset = 1'b0;
        step();
        check("areset idle after", int'(bus8.state), 0);
        for (int i = 0; i < 32; i++) pat[i] = tbl[0].mask[i];
        run_window("after reset", 8, 3, 1, 3, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_rate_monitor.md
PULSE_RATE_MONITOR -- requirements
Module: pulse_rate_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, pulse-count width.
REQ-002 SHALL have parameter WIN_W, default 8, window-length and window-timer width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports are named clock and reset.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  async active-high reset.
REQ-006 enable  input  1  run request; 1 = measure windows back-to-back.
REQ-007 pulse_in  input  1  one-cycle change pulse from the upstream transition-detector FSM output.
REQ-008 window_len  input  WIN_W  window length in clocks; 0 is treated as 1.
REQ-009 threshold  input  CNT_W  alarm threshold.
REQ-010 rdy  input  1  consumer accepts count_out.
REQ-011 count_out  output  CNT_W  pulses counted in the last completed window.
REQ-012 count_valid  output  1  count_out is valid and awaiting rdy.
REQ-013 alarm  output  1  last window count >= threshold.
REQ-014 overflow  output  1  last window count saturated.
REQ-015 state  output  2  present state: IDLE=2'b00, COUNT=2'b01, REPORT=2'b10.

Function
REQ-016 All outputs and internal registers SHALL update only on rising clock edges, except on reset.
REQ-017 IDLE: if enable=1, SHALL go to COUNT and clear the pulse counter and window timer; window_len and threshold are captured at this edge.
REQ-018 COUNT: the window timer SHALL increment every cycle; pulse_in=1 increments the counter.
REQ-019 The counter SHALL saturate at 2^CNT_W-1; any pulse arriving at saturation sets the internal overflow flag for that window.
REQ-020 Window end is the cycle in which timer = captured window_len-1, so COUNT lasts exactly window_len cycles; a pulse in that cycle SHALL be counted.
REQ-021 At window end the block SHALL, on the same edge:
- load count_out with the final count;
- set count_valid=1;
- set alarm = (final count >= captured threshold);
- load overflow from the internal flag;
- go to REPORT.
REQ-022 REPORT: count_out, alarm and overflow SHALL hold stable while count_valid=1; pulse_in is ignored.
REQ-023 A handshake occurs on an edge where count_valid=1 and rdy=1; count_valid SHALL clear on that edge.
REQ-024 On a handshake with enable=1, SHALL go to COUNT with cleared counter/timer and recapture window_len and threshold; with enable=0, SHALL go to IDLE.
REQ-025 rdy=1 while count_valid=0 SHALL have no effect.
REQ-026 enable=0 sampled in COUNT SHALL abort to IDLE next edge, discard the partial count, and leave count_out, alarm and overflow unchanged.
REQ-027 enable=0 in REPORT SHALL NOT drop count_valid; the pending result SHALL wait for rdy.
REQ-028 Unused state encoding 2'b11 SHALL go to IDLE next edge.
REQ-029 Latency from window end to count_valid=1 SHALL be 0 cycles (registered at the window-end edge).
REQ-030 Timer arithmetic SHALL be unsigned, WIN_W bits, with no wrap within a window.

Reset
REQ-031 reset=1 SHALL immediately force state=IDLE and clear count_out, count_valid, alarm, overflow, the counter, the timer and the captured registers, regardless of the clock.
REQ-032 Reset asserted mid-window or during REPORT SHALL discard all pending data; operation resumes from IDLE after reset deasserts.

Structure
REQ-033 State encodings and default CNT_W/WIN_W SHALL live in shared package pulse_mon_pkg.
REQ-034 The window timer (load, increment, terminal-count flag) SHALL be a sub-module named window_timer; the FSM, counter and output registers SHALL live in pulse_rate_monitor.

Verification
REQ-035 The bench SHALL cover, at minimum:
- Basic window: window_len=8, threshold=3, 3 pulses at cycles 1,4,7, rdy=1 -> count_out=3, alarm=1, count_valid high exactly 1 cycle at window end.
- Backpressure: window_len=4, 2 pulses, rdy=0 for 5 cycles then 1 -> count_valid held 6 cycles, count_out=2 stable, pulses during REPORT not counted in the next window.
- Saturation: CNT_W=8, window_len=0 treated as 1... use window_len=255 with pulse_in=1 every cycle -> count_out=255, overflow=0; then CNT_W=4, window_len=20, continuous pulses -> count_out=15, overflow=1.
- Abort: enable dropped at cycle 3 of an 8-cycle window -> state IDLE next edge, count_valid stays 0, count_out keeps its previous value.
- Async reset in REPORT: reset pulse between clock edges -> count_valid=0 and state=IDLE before the next edge.
- Boundary: window_len=0, pulse_in=1 -> 1-cycle window, count_out=1; threshold=0 -> alarm=1 for a zero-pulse window.
